// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - Morse state encodings, timing limits and the A..H code table.
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  localparam logic [2:0] DOT_MAX     = 3'd2;
  localparam logic [2:0] DASH_MAX    = 3'd4;
  localparam logic [2:0] LETTER_GAP  = 3'd3;
  localparam logic [2:0] MAX_SYMBOLS = 3'd4;
  localparam int         NUM_LETTERS = 8;

  // Codes are MSB-first and left-aligned; 1 = dash, 0 = dot.
  localparam logic [3:0] LETTER_CODE [NUM_LETTERS] = '{
    4'b0100, 4'b1000, 4'b1010, 4'b1000,
    4'b0000, 4'b0010, 4'b1100, 4'b0000
  };
  localparam logic [2:0] LETTER_SIZE [NUM_LETTERS] = '{
    3'd2, 3'd4, 3'd4, 3'd3,
    3'd1, 3'd4, 3'd3, 3'd4
  };

  typedef struct packed {
    logic       ok;
    logic [2:0] idx;
  } letter_t;

  function automatic letter_t decode_letter(input logic [3:0] code, input logic [2:0] len);
    letter_t r;
    r = '0;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      if (LETTER_CODE[i] == code && LETTER_SIZE[i] == len) begin
        r.ok  = 1'b1;
        r.idx = 3'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/key_sync.sv
// rtl/key_sync.sv - Two-flop synchronizer for the asynchronous Morse key.
module key_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic key_s_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= key_i;
      sync_q <= meta_q;
    end
  end

  assign key_s_o = sync_q;

endmodule

// File: rtl/morse_receiver.sv
// rtl/morse_receiver.sv - Tick-timed Morse receiver decoding letters A..H.
module morse_receiver
  import morse_pkg::*;
(
  input  logic       Clock,
  input  logic       reset,
  input  logic       en_clk,
  input  logic       key,
  output logic [3:0] data,
  output logic [2:0] size,
  output logic       valid,
  output logic [2:0] letter,
  output logic       letter_ok,
  output logic       error
);

  logic       key_s;
  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] n_q, n_d;
  logic [3:0] shift_q, shift_d;
  logic [3:0] data_q, data_d;
  logic [2:0] size_q, size_d;
  logic [2:0] letter_q, letter_d;
  logic       letter_ok_q, letter_ok_d;
  logic       valid_q, valid_d;
  logic       error_q, error_d;
  logic [2:0] cnt_inc;
  logic       sym;
  letter_t    dec;

  key_sync u_key_sync (
    .clk_i   (Clock),
    .rst_i   (reset),
    .key_i   (key),
    .key_s_o (key_s)
  );

  assign cnt_inc = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
  assign sym     = (cnt_q > DOT_MAX);
  assign dec     = decode_letter(shift_q, n_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    shift_d     = shift_q;
    data_d      = data_q;
    size_d      = size_q;
    letter_d    = letter_q;
    letter_ok_d = letter_ok_q;
    valid_d     = 1'b0;
    error_d     = 1'b0;
    if (en_clk) begin
      unique case (state_q)
        ST_IDLE: begin
          if (key_s) begin
            state_d = ST_MARK;
            cnt_d   = 3'd1;
            n_d     = 3'd0;
            shift_d = 4'b0000;
          end
        end
        ST_MARK: begin
          if (key_s) begin
            cnt_d = cnt_inc;
            if (cnt_inc > DASH_MAX) begin
              state_d = ST_ERR;
              cnt_d   = 3'd0;
              error_d = 1'b1;
            end
          end else if (n_q == MAX_SYMBOLS) begin
            state_d = ST_ERR;
            cnt_d   = 3'd0;
            error_d = 1'b1;
          end else begin
            shift_d[2'd3 - n_q[1:0]] = sym;
            n_d     = n_q + 3'd1;
            state_d = ST_SPACE;
            cnt_d   = 3'd1;
          end
        end
        ST_SPACE: begin
          if (key_s) begin
            state_d = ST_MARK;
            cnt_d   = 3'd1;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == LETTER_GAP) begin
              state_d     = ST_IDLE;
              cnt_d       = 3'd0;
              data_d      = shift_q;
              size_d      = n_q;
              letter_d    = dec.idx;
              letter_ok_d = dec.ok;
              valid_d     = 1'b1;
            end
          end
        end
        ST_ERR: begin
          // Any key press restarts the quiet-time count needed to leave ERR.
          if (key_s) begin
            cnt_d = 3'd0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == LETTER_GAP) begin
              state_d = ST_IDLE;
              cnt_d   = 3'd0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      shift_q     <= 4'b0000;
      data_q      <= 4'b0000;
      size_q      <= 3'd0;
      letter_q    <= 3'd0;
      letter_ok_q <= 1'b0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      size_q      <= size_d;
      letter_q    <= letter_d;
      letter_ok_q <= letter_ok_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
    end
  end

  assign data      = data_q;
  assign size      = size_q;
  assign letter    = letter_q;
  assign letter_ok = letter_ok_q;
  assign valid     = valid_q;
  assign error     = error_q;

endmodule

// File: tb/tb_morse_receiver.sv
// tb/tb_morse_receiver.sv - Scoreboard bench for morse_receiver.
module tb_morse_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_clk = 1'b0;
  logic       key = 1'b0;
  logic [3:0] data;
  logic [2:0] size;
  logic       valid;
  logic [2:0] letter;
  logic       letter_ok;
  logic       error;

  typedef struct {
    logic       is_err;
    logic [3:0] data;
    logic [2:0] size;
    logic [2:0] letter;
    logic       ok;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;

  morse_receiver dut (
    .Clock     (clk),
    .reset     (rst),
    .en_clk    (en_clk),
    .key       (key),
    .data      (data),
    .size      (size),
    .valid     (valid),
    .letter    (letter),
    .letter_ok (letter_ok),
    .error     (error)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Every output event of the DUT must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (valid || error)) begin
      ev_t e;
      chk("valid_error_exclusive", 8'(valid & error), 8'd0);
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_event observed valid=%0b error=%0b expected none", valid, error);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("event_is_error", 8'(error), 8'(e.is_err));
        if (!e.is_err) begin
          chk("data", 8'(data), 8'(e.data));
          chk("size", 8'(size), 8'(e.size));
          chk("letter", 8'(letter), 8'(e.letter));
          chk("letter_ok", 8'(letter_ok), 8'(e.ok));
        end
      end
    end
  end

  task automatic push_letter(input logic [3:0] d, input logic [2:0] s,
                             input logic [2:0] l, input logic ok);
    ev_t e;
    e.is_err = 1'b0; e.data = d; e.size = s; e.letter = l; e.ok = ok;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    ev_t e;
    e.is_err = 1'b1; e.data = '0; e.size = '0; e.letter = '0; e.ok = 1'b0;
    exp_q.push_back(e);
  endtask

  // One tick with key held at k; every expected event must be consumed by its end.
  task automatic tick(input logic k);
    @(negedge clk) key = k;
    repeat (3) @(negedge clk);
    en_clk = 1'b1;
    @(negedge clk) en_clk = 1'b0;
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
  endtask

  task automatic glitch();
    @(negedge clk) key = 1'b1;
    repeat (3) @(negedge clk);
    key = 1'b0;
  endtask

  task automatic ticks(input logic k, input int n);
    for (int i = 0; i < n; i++) tick(k);
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] d, input logic [2:0] s,
                               input logic [2:0] l, input logic ok);
    chk({tag, "_data"}, 8'(data), 8'(d));
    chk({tag, "_size"}, 8'(size), 8'(s));
    chk({tag, "_letter"}, 8'(letter), 8'(l));
    chk({tag, "_letter_ok"}, 8'(letter_ok), 8'(ok));
    chk({tag, "_valid"}, 8'(valid), 8'd0);
    chk({tag, "_error"}, 8'(error), 8'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_outputs("reset", 4'b0000, 3'd0, 3'd0, 1'b0);
    rst = 1'b0;

    // A: .-
    tick(1); tick(0); ticks(1, 3); ticks(0, 2);
    push_letter(4'b0100, 3'd2, 3'd0, 1'b1); tick(0);

    // C: -.-.
    ticks(1, 3); tick(0); tick(1); tick(0); ticks(1, 3); tick(0); tick(1); ticks(0, 2);
    push_letter(4'b1010, 3'd4, 3'd2, 1'b1); tick(0);
    check_outputs("hold_after_C", 4'b1010, 3'd4, 3'd2, 1'b1);

    // Overlong mark: error on the fifth high tick, then recovery and E
    ticks(1, 4); push_err(); tick(1);
    ticks(0, 3);
    tick(1); ticks(0, 2);
    push_letter(4'b0000, 3'd1, 3'd4, 1'b1); tick(0);

    // Five dots: error on recording the fifth symbol, outputs keep E
    for (int i = 0; i < 4; i++) begin tick(1); tick(0); end
    tick(1); push_err(); tick(0);
    ticks(0, 3);
    check_outputs("hold_after_err", 4'b0000, 3'd1, 3'd4, 1'b1);

    // Glitches between ticks are invisible; E decodes around them
    glitch(); tick(0);
    tick(1); tick(0); glitch(); tick(0);
    push_letter(4'b0000, 3'd1, 3'd4, 1'b1); glitch(); tick(0);

    // Four dashes: valid but no letter
    for (int i = 0; i < 3; i++) begin ticks(1, 3); tick(0); end
    ticks(1, 3); ticks(0, 2);
    push_letter(4'b1111, 3'd4, 3'd0, 1'b0); tick(0);
    check_outputs("hold_dddd", 4'b1111, 3'd4, 3'd0, 1'b0);

    // Reset in the middle of the next dash clears outputs without a clock edge
    ticks(1, 2);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_outputs("async_reset", 4'b0000, 3'd0, 3'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ticks(0, 4);
    check_outputs("after_reset", 4'b0000, 3'd0, 3'd0, 1'b0);

    // Key held through reset release starts a mark on the first tick
    @(negedge clk) rst = 1'b1; key = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick(1); ticks(0, 2);
    push_letter(4'b0000, 3'd1, 3'd4, 1'b1); tick(0);

    repeat (5) @(negedge clk);
    chk("final_scoreboard_empty", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/morse_receiver.md
MORSE_RECEIVER -- requirements
Module: morse_receiver

Interface
REQ-001 Clock  input  1  system clock; all state updates on posedge Clock.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 en_clk  input  1  one-Clock-cycle pulse every 0.5 s; all duration measurement advances only on cycles where en_clk=1 (one "tick").
REQ-004 key  input  1  asynchronous Morse key (1 = pressed); synchronized internally.
REQ-005 data  output  4  received symbols, MSB-first, left-aligned, 1 = dash, 0 = dot, unused LSBs 0.
REQ-006 size  output  3  number of symbols in data, 1..4.
REQ-007 valid  output  1  one-Clock-cycle pulse: data/size/letter/letter_ok updated.
REQ-008 letter  output  3  index of decoded letter, A=0 .. H=7.
REQ-009 letter_ok  output  1  1 when data/size match one of A..H.
REQ-010 error  output  1  one-Clock-cycle pulse on malformed input.

Function
REQ-011 key SHALL pass through a two-flop synchronizer; key_s is the synchronized value; only key_s is sampled, and only on ticks.
REQ-012 States SHALL be IDLE, MARK, SPACE, ERR; 3-bit tick counter cnt saturates at 7.
REQ-013 IDLE: on tick with key_s=1 -> MARK, cnt=1, symbol count n=0, shift register cleared.
REQ-014 MARK: on tick with key_s=1, cnt increments; cnt reaching 5 -> ERR.
REQ-015 MARK: on tick with key_s=0, cnt 1..2 SHALL record dot, cnt 3..4 SHALL record dash; symbol shifted in at bit (3-n), n increments, -> SPACE with cnt=1.
REQ-016 Recording a fifth symbol (n already 4) SHALL -> ERR instead.
REQ-017 SPACE: on tick with key_s=1 -> MARK, cnt=1; on tick with key_s=0, cnt increments.
REQ-018 SPACE: when cnt reaches 3 -> IDLE, and on that same cycle data, size=n, letter, letter_ok register and valid=1.
REQ-019 Letter table: A 01/2, B 1000/4, C 1010/4, D 100/3, E 0/1, F 0010/4, G 110/3, H 0000/4 (data bits MSB-first / size); no match -> letter_ok=0, letter=0.
REQ-020 ERR: error=1 on the entry cycle only; remain in ERR until key_s=0 for 3 consecutive ticks, then IDLE; no valid issued for the aborted letter.
REQ-021 data, size, letter, letter_ok SHALL hold between valid pulses; valid and error never both 1.
REQ-022 key changes between ticks SHALL be ignored; en_clk=0 freezes state and cnt.

Reset
REQ-023 reset=1 SHALL immediately force state IDLE, cnt=0, n=0, data=0, size=0, letter=0, letter_ok=0, valid=0, error=0, synchronizer flops 0.
REQ-024 reset mid-letter SHALL discard partial symbols; no valid or error after release.
REQ-025 key held at reset release SHALL be treated as a new mark starting at the first tick.

Structure
REQ-026 Shared package morse_pkg SHALL hold state encodings, DOT_MAX=2, DASH_MAX=4, LETTER_GAP=3, MAX_SYMBOLS=4 and the A..H code/size table, shared with the transmitter.
REQ-027 Synchronizer SHALL be a sub-module named key_sync; all else in morse_receiver.

Verification
REQ-028 Key high 1 tick, low 1, high 3, low 3 -> one valid; data=0100, size=2, letter=0 (A), letter_ok=1.
REQ-029 Key high 3, low 1, high 1, low 1, high 3, low 1, high 1, low 3 -> data=1010, size=4, letter=2 (C), letter_ok=1.
REQ-030 Key high 5 ticks -> error pulse on fifth tick, no valid; after 3 low ticks, E (high 1, low 3) decodes letter=4, size=1.
REQ-031 Five dots with 1-tick gaps -> error on fifth symbol; data/size retain previous letter.
REQ-032 Pattern ---- (4 dashes) -> valid, data=1111, size=4, letter_ok=0; reset asserted mid-dash of next letter -> all outputs 0 asynchronously, no valid afterwards.
REQ-033 key glitch high for 3 Clock cycles between ticks -> no state change.
